// File: rtl/ht_stf_symbol_streamer_pkg.sv
// Shared TX preamble definitions: streamer state enum, subcarrier count and
// the bin-to-ROM-address mapping used by the STF/LTF streamers.
package ht_stf_symbol_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  localparam int N_SC = 64;

  // Shifted order flips the MSB so bin 0 reads the DC subcarrier (ROM addr 32).
  function automatic logic [6:0] bin_to_addr(input logic [5:0] bin, input logic fft_shift);
    return {1'b0, (fft_shift ? (bin ^ 6'h20) : bin)};
  endfunction

endpackage

// File: rtl/ht_stf_symbol_streamer.sv
// Walks a 64-entry preamble ROM NUM_SYM times and streams each registered word
// over valid/ready with a per-symbol last marker and a done pulse.
module ht_stf_symbol_streamer
  import ht_stf_symbol_streamer_pkg::*;
#(
  parameter int NUM_SYM   = 1,
  parameter bit FFT_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam logic [5:0] LAST_BIN = 6'(N_SC - 1);
  localparam logic [3:0] LAST_SYM = 4'(NUM_SYM - 1);

  tx_state_e   state_q, state_d;
  logic [5:0]  bin_q, bin_d;
  logic [3:0]  sym_q, sym_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;

  logic hshake, load, final_beat;

  assign hshake     = out_valid_q & out_ready;
  assign load       = (state_q == ST_RUN) & (~out_valid_q | out_ready);
  assign final_beat = (bin_q == LAST_BIN) & (sym_q == LAST_SYM);

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    sym_d       = sym_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (hshake) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_q still high means this is the completion cycle; stay idle.
        if (start && !done_q) begin
          state_d = ST_RUN;
          bin_d   = '0;
          sym_d   = '0;
        end
      end
      ST_RUN: begin
        if (load) begin
          out_data_d  = rom_dout;
          out_last_d  = (bin_q == LAST_BIN);
          out_valid_d = 1'b1;
          bin_d       = bin_q + 6'd1;
          if (bin_q == LAST_BIN) sym_d = final_beat ? 4'd0 : sym_q + 4'd1;
          if (final_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hshake) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      sym_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      sym_q       <= sym_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Address only driven while sweeping so an idle ROM port sits at 0.
  assign rom_addr  = (state_q == ST_RUN) ? bin_to_addr(bin_q, FFT_SHIFT) : 7'd0;
  assign busy      = (state_q != ST_IDLE) | done_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ht_stf_symbol_streamer.sv
// Scoreboard bench: two streamer configurations driven from a shared ROM model,
// expected beats queued at start and popped by a monitor on each handshake.
module tb_ht_stf_symbol_streamer;

  localparam logic [31:0] POS = 32'h61C0_61C0;
  localparam logic [31:0] NEG = 32'h9E40_9E40;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start [2];
  logic        out_ready [2];
  logic        busy [2];
  logic        done [2];
  logic        out_valid [2];
  logic        out_last [2];
  logic [6:0]  rom_addr [2];
  logic [31:0] rom_dout [2];
  logic [31:0] out_data [2];
  logic [31:0] rom_mem [64];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int beats [2];
  int done_cnt [2];
  int done_cyc [2];
  int first_cyc [2];
  logic [32:0] exp0 [$];
  logic [32:0] exp1 [$];
  logic [31:0] log_d0 [$];
  logic [31:0] log_d1 [$];
  bit          log_l0 [$];
  bit          log_l1 [$];
  bit          stall_prev [2];
  bit          done_prev [2];
  logic [31:0] prev_d [2];
  logic        prev_l [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_dout[0] = rom_mem[rom_addr[0][5:0]];
  assign rom_dout[1] = rom_mem[rom_addr[1][5:0]];

  ht_stf_symbol_streamer #(.NUM_SYM(1), .FFT_SHIFT(1'b1)) u_dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rom_addr(rom_addr[0]), .rom_dout(rom_dout[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0])
  );

  ht_stf_symbol_streamer #(.NUM_SYM(2), .FFT_SHIFT(1'b0)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rom_addr(rom_addr[1]), .rom_dout(rom_dout[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall hold and done.
  always @(negedge clk) begin
    logic [32:0] e;
    bit got;
    if (!rstn) begin
      stall_prev = '{0, 0};
      done_prev  = '{0, 0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (stall_prev[k])
          check($sformatf("stall_hold%0d", k), {out_valid[k], out_last[k], out_data[k]},
                {1'b1, prev_l[k], prev_d[k]});
        if (out_valid[k] && out_ready[k]) begin
          got = 0;
          e   = '0;
          if (k == 0 && exp0.size() > 0) begin e = exp0.pop_front(); got = 1; end
          if (k == 1 && exp1.size() > 0) begin e = exp1.pop_front(); got = 1; end
          if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_beat%0d: beat %0d data %h arrived, none expected", k, beats[k], out_data[k]);
          end else begin
            check($sformatf("beat%0d_%0d", k, beats[k]), {out_last[k], out_data[k]}, e);
          end
          if (beats[k] == 0) first_cyc[k] = cyc;
          if (k == 0) begin log_d0.push_back(out_data[0]); log_l0.push_back(out_last[0]); end
          else        begin log_d1.push_back(out_data[1]); log_l1.push_back(out_last[1]); end
          beats[k]++;
        end
        stall_prev[k] = out_valid[k] && !out_ready[k];
        prev_d[k]     = out_data[k];
        prev_l[k]     = out_last[k];
        if (done[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          check($sformatf("done_single%0d", k), done_prev[k], 0);
          check($sformatf("done_drained%0d", k), (k == 0) ? exp0.size() : exp1.size(), 0);
        end
        done_prev[k] = done[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_busy%0d", tag, k), busy[k], 0);
      check($sformatf("%s_done%0d", tag, k), done[k], 0);
      check($sformatf("%s_valid%0d", tag, k), out_valid[k], 0);
      check($sformatf("%s_last%0d", tag, k), out_last[k], 0);
      check($sformatf("%s_data%0d", tag, k), out_data[k], 0);
      check($sformatf("%s_addr%0d", tag, k), rom_addr[k], 0);
    end
  endtask

  // Reference: symbol s, position b reads subcarrier (b+32) mod 64 when shifted.
  task automatic push_burst(input int k);
    int nsym;
    int a;
    logic [32:0] w;
    nsym = (k == 0) ? 1 : 2;
    for (int s = 0; s < nsym; s++)
      for (int b = 0; b < 64; b++) begin
        a = (k == 0) ? (b + 32) % 64 : b;
        w = {(b == 63), rom_mem[a]};
        if (k == 0) exp0.push_back(w); else exp1.push_back(w);
      end
  endtask

  task automatic clear_logs(input int k);
    beats[k] = 0;
    if (k == 0) begin log_d0.delete(); log_l0.delete(); end
    else        begin log_d1.delete(); log_l1.delete(); end
  endtask

  task automatic run_burst(input int k, input int budget, input bit rnd_ready, output int st_cyc);
    int d0;
    int i;
    d0 = done_cnt[k];
    clear_logs(k);
    push_burst(k);
    start[k] = 1'b1;
    st_cyc   = cyc + 1;
    tick();
    start[k] = 1'b0;
    i = 0;
    while (done_cnt[k] == d0 && i < budget) begin
      if (rnd_ready) out_ready[k] = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    out_ready[k] = 1'b1;
    tick();
    check($sformatf("burst_done%0d", k), done_cnt[k] - d0, 1);
    check($sformatf("burst_beats%0d", k), beats[k], (k == 0) ? 64 : 128);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int st;
    int d0;
    int nz;
    int nl;
    int g;
    start     = '{0, 0};
    out_ready = '{1, 1};
    beats     = '{0, 0};
    done_cnt  = '{0, 0};
    done_cyc  = '{0, 0};
    first_cyc = '{0, 0};
    for (int i = 0; i < 64; i++) rom_mem[i] = '0;
    rom_mem[4]  = NEG; rom_mem[8]  = NEG; rom_mem[12] = POS; rom_mem[16] = POS;
    rom_mem[20] = POS; rom_mem[24] = POS; rom_mem[60] = POS; rom_mem[56] = NEG;
    rom_mem[52] = NEG; rom_mem[48] = POS; rom_mem[44] = NEG; rom_mem[40] = POS;

    repeat (3) tick();
    chk_idle("rst");
    rstn = 1'b1;
    repeat (4) tick();
    chk_idle("idle");

    // Shifted order, one symbol.
    run_burst(0, 300, 0, st);
    check("a_first_lat", first_cyc[0] - st, 1);
    check("a_done_lat", done_cyc[0] - st, 65);
    check("a_size", log_d0.size(), 64);
    if (log_d0.size() == 64) begin
      check("a_beat8", log_d0[8], POS);
      check("a_beat36", log_d0[36], NEG);
      check("a_beat0", log_d0[0], 0);
      check("a_last63", log_l0[63], 1);
      nz = 0; nl = 0;
      for (int i = 0; i < 64; i++) begin
        if (log_d0[i] != 0) nz++;
        if (log_l0[i]) nl++;
      end
      check("a_nonzero", nz, 12);
      check("a_last_cnt", nl, 1);
    end

    // Unshifted order, two symbols.
    run_burst(1, 400, 0, st);
    check("b_done_lat", done_cyc[1] - st, 129);
    check("b_size", log_d1.size(), 128);
    if (log_d1.size() == 128) begin
      check("b_beat4", log_d1[4], NEG);
      check("b_beat68", log_d1[68], NEG);
      check("b_beat12", log_d1[12], POS);
      check("b_last63", log_l1[63], 1);
      check("b_last127", log_l1[127], 1);
      nl = 0;
      for (int i = 0; i < 128; i++) if (log_l1[i]) nl++;
      check("b_last_cnt", nl, 2);
    end

    // Random ROM contents under random backpressure.
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    for (int r = 0; r < 2; r++) begin
      run_burst(0, 3000, 1, st);
      run_burst(1, 5000, 1, st);
    end

    // Start pulses mid-burst and on the done cycle must be ignored.
    d0 = done_cnt[0];
    clear_logs(0);
    push_burst(0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (20) tick();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    g = 0;
    while (!done[0] && g < 300) begin tick(); g++; end
    check("sb_done_seen", done[0], 1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (100) tick();
    check("sb_done_cnt", done_cnt[0] - d0, 1);
    check("sb_beats", beats[0], 64);
    check("sb_busy", busy[0], 0);

    // Reset mid-burst, then a clean burst.
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    clear_logs(0);
    push_burst(0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    g = 0;
    while (beats[0] < 20 && g < 300) begin tick(); g++; end
    check("mr_reached20", beats[0] >= 20, 1);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk_idle("mr");
    exp0.delete();
    d0 = done_cnt[0];
    repeat (3) tick();
    rstn = 1'b1;
    repeat (5) tick();
    check("mr_no_done", done_cnt[0] - d0, 0);
    run_burst(0, 300, 0, st);
    check("mr_done_lat", done_cyc[0] - st, 65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ht_stf_symbol_streamer.md
# ht_stf_symbol_streamer

Sequencer that sits directly downstream of the HT-STF subcarrier ROM (`ans_ht_stf_rom`) in the OFDM TX chain. On a start pulse, it walks the ROM's 64 subcarrier addresses, optionally in FFT bin order. It registers each ROM word and streams it to the IFFT input over a valid/ready handshake, with a per-symbol `last` marker. It repeats the sweep for a configurable number of symbols and reports completion with a single-cycle `done` pulse.

## Interface
- `NUM_SYM`, default 1: symbols streamed per start; legal range 1..15.
- `FFT_SHIFT`, default 1: 1 = emit in natural IFFT bin order (DC first); 0 = emit in subcarrier order −32..31.
- `clk` in 1: clock. Single clock domain.
- `rstn` in 1: reset. Asynchronous assert, active-low.
- `start` in 1: single-cycle request to begin a burst. Ignored while `busy`=1.
- `busy` out 1: high from the cycle after an accepted `start` through the cycle that asserts `done`.
- `done` out 1: single-cycle pulse after the final handshake of the burst.
- `rom_addr` out 7: address to the ROM. Bit 6 is always 0.
- `rom_dout` in 32: combinational ROM word, {I[31:16], Q[15:0]}.
- `out_data` out 32: registered subcarrier word, same packing as `rom_dout`.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts a beat when `out_valid` & `out_ready`.
- `out_last` out 1: marks the final beat of each symbol (bin 63).

## Operation
- **States.**
  - IDLE → RUN on `start`.
  - RUN → DRAIN when the final beat is loaded into the output register.
  - DRAIN → IDLE when that beat handshakes. `done`=1 in the DRAIN→IDLE transition cycle.
- **Counters.**
  - `bin` is 6 bits, wraps 63→0.
  - `sym` is 4 bits and increments on the `bin` wrap.
  - The final beat is `bin`=63 with `sym`=NUM_SYM−1.
- **Address mapping.**
  - `rom_addr` = {1'b0, `bin` ^ 6'h20} when FFT_SHIFT=1.
  - `rom_addr` = {1'b0, `bin`} when FFT_SHIFT=0.
- **Output register load.**
  - Load condition: state RUN and (`out_valid`=0 or `out_ready`=1).
  - On load: `out_data`←`rom_dout`, `out_last`←(`bin`==63), `out_valid`←1, and the counters advance.
  - If `out_valid`=1 and `out_ready`=0: hold `out_data`, `out_last` and the counters unchanged.
  - Clear `out_valid` on a handshake with no new load.
- **ROM data.** Data is passed bit-exact; no arithmetic is applied.
- **Reset values.** `rstn` low forces IDLE, counters 0, and `busy`, `done`, `out_valid`, `out_last`, `out_data`, `rom_addr` all 0, regardless of state. Reset mid-burst abandons the burst with no `done`.
- **Start handling.** `start` in the same cycle as `done` is ignored; a new burst needs `start` at least one cycle after `done`.

## Timing
- `start` sampled at edge T0. `busy`=1 and first `out_valid`=1 after edge T1: 1-cycle latency.
- With `out_ready` held high: one beat per cycle, 64×NUM_SYM consecutive beats, no bubbles between symbols.
- `done` rises in the cycle following the final handshake; `busy` falls with `done`.
- Backpressure: a data beat never changes while `out_valid`=1 and `out_ready`=0. Throughput recovers to 1 beat/cycle the cycle `out_ready` returns.
- Total burst with no stalls: `start` to `done` = 64×NUM_SYM + 1 cycles.

## Structure
- Shared TX package holds:
  - the state enum (IDLE, RUN, DRAIN);
  - constant `N_SC`=64;
  - the bin-to-address mapping function (also reused by the L-STF/LTF streamers).
- `ans_ht_stf_rom` is instantiated at the parent level, not inside this block, so the same streamer can drive other preamble ROMs.
- No internal sub-modules; a single FSM plus two counters and one output register.

## Test plan
- **Reset and idle.** Reset, then idle with `start`=0 → all outputs 0; `rom_addr` stays 0.
- **Shifted order, one symbol.** FFT_SHIFT=1, NUM_SYM=1, `out_ready`=1, `start` pulse →
  - beats 0..63 arrive on consecutive cycles, starting 1 cycle after `start`;
  - beat 8 = 32'h61C0_61C0 (ROM addr 40);
  - beat 36 = 32'h9E40_9E40 (ROM addr 4);
  - beat 0 = 0;
  - exactly 12 nonzero beats;
  - `out_last` only on beat 63;
  - `done` one cycle later.
- **Unshifted order, two symbols.** FFT_SHIFT=0, NUM_SYM=2 →
  - beat 4 and beat 68 = 32'h9E40_9E40;
  - beat 12 = 32'h61C0_61C0;
  - `out_last` on beats 63 and 127;
  - 129 cycles from `start` to `done`.
- **Random backpressure.** Random `out_ready` (~50%) → beat sequence identical to the stall-free run; `out_data` stable during every stall; no beats lost or duplicated.
- **Start while busy.** `start` pulsed during a burst and again on the `done` cycle → both ignored; beat count stays 64×NUM_SYM; no second burst begins.
- **Reset mid-burst.** `rstn` asserted at beat 20 → outputs 0 immediately (asynchronous), no `done`. After release, a fresh `start` produces a complete, correct burst from beat 0.
